// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: the NOP encoding used for fetch bubbles,
// the jump/branch opcodes, and the next-PC source select used by fetch.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JR,
    PC_JUMP
  } pc_sel_e;

  // Primary opcode field of an instruction word, as seen by the decoder.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus seen by the fetch stage: a byte address driven by
// fetch and a word returned combinationally by the memory.
interface fetch_stage_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority selector for the fetch stage. Purely combinational:
// taken branch beats stall, stall beats jr, jr beats j/jal, otherwise PC+4.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_q_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic [ADDR_W-1:0] if_id_pc4_i,
  output pc_sel_e           pc_sel_o,
  output logic              hold_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  // Only the segment bits of PC+4 feed a j/jal target, and jr targets are
  // forced word aligned, so these low bits are intentionally dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{if_id_pc4_i[27:0], jr_target_i[1:0]};

  // Resolve the redirect source in age order; the EX-stage branch is older
  // than anything in ID, so it wins even over a load-use stall.
  always_comb begin
    pc_sel_o  = PC_SEQ;
    hold_o    = 1'b0;
    pc_next_o = pc_q_i + ADDR_W'(4);
    if (branch_taken_i) begin
      pc_sel_o  = PC_BRANCH;
      pc_next_o = branch_target_i;
    end else if (stall_i) begin
      hold_o    = 1'b1;
      pc_next_o = pc_q_i;
    end else if (jr_i) begin
      pc_sel_o  = PC_JR;
      pc_next_o = {jr_target_i[ADDR_W-1:2], 2'b00};
    end else if (jump_i) begin
      pc_sel_o  = PC_JUMP;
      pc_next_o = {if_id_pc4_i[ADDR_W-1:28], jump_index_i, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, instruction-memory address
// and the IF/ID pipeline register. Redirects (branch, jr, j/jal) load a NOP
// bubble into IF/ID; a load-use stall freezes both PC and IF/ID.
// Optional build macro FETCH_PERF_EN adds fetch/bubble performance counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  fetch_stage_if.master     imem,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic [5:0]        instr_op_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  pc_sel_e           pc_sel;
  logic              hold;
  logic [ADDR_W-1:0] pc_next;
  logic              load_fetch;
  logic              load_bubble;

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_sel (
    .pc_q_i         (pc_q),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_index_i   (jump_index_i),
    .jr_i           (jr_i),
    .jr_target_i    (jr_target_i),
    .if_id_pc4_i    (pc4_q),
    .pc_sel_o       (pc_sel),
    .hold_o         (hold),
    .pc_next_o      (pc_next)
  );

  assign imem.imem_addr = pc_q;

  assign load_fetch  = !hold && (pc_sel == PC_SEQ);
  assign load_bubble = !hold && (pc_sel != PC_SEQ);

  // Next PC and IF/ID contents: capture the fetched word on a sequential
  // step, insert a NOP bubble on any redirect, hold everything on stall.
  always_comb begin
    pc_d    = pc_next;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load_fetch) begin
      instr_d = imem.imem_data;
      pc4_d   = pc_next;
      valid_d = 1'b1;
    end else if (load_bubble) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  // PC and IF/ID registers; reset discards any pending redirect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign instr_op_o    = opcode_of(instr_q);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count IF/ID loads by kind; stall-hold cycles load nothing and count nothing.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_fetch)  fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (load_bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Performance counter registers, free-running and wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt_o  = fetch_cnt_q;
  assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized redirect /
// stall traffic, all checked against a behavioural model of the fetch rules.
// Honours FETCH_PERF_EN when defined.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_index_i = '0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_target_i = '0;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [5:0]  instr_op_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_bubble_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  logic mem_mode = 1'b0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch, m_bubble;

  fetch_stage_if #(.ADDR_W(32)) imem ();

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic mode);
    if (mode) return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    return a;
  endfunction

  assign imem.imem_data = mem_word(imem.imem_addr, mem_mode);

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .imem            (imem),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .instr_op_o      (instr_op_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_bubble_cnt_o(perf_bubble_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fetch = 32'h0; m_bubble = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/addr"},  imem.imem_addr, m_pc);
    check({tag, "/instr"}, if_id_instr_o, m_instr);
    check({tag, "/pc4"},   if_id_pc4_o, m_pc4);
    check({tag, "/valid"}, {31'b0, if_id_valid_o}, {31'b0, m_valid});
    check({tag, "/op"},    {26'b0, instr_op_o}, {26'b0, m_instr[31:26]});
`ifdef FETCH_PERF_EN
    check({tag, "/pfetch"},  perf_fetch_cnt_o, m_fetch);
    check({tag, "/pbubble"}, perf_bubble_cnt_o, m_bubble);
`endif
  endtask

  // One clock: predict from the rules, let the edge happen, then compare.
  task automatic tick(input string tag);
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid, bubble;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; bubble = 1'b0;
    if (branch_taken_i) begin
      n_pc = branch_target_i; bubble = 1'b1;
    end else if (stall_i) begin
      n_pc = m_pc;
    end else if (jr_i) begin
      n_pc = jr_target_i & 32'hFFFF_FFFC; bubble = 1'b1;
    end else if (jump_i) begin
      n_pc = (m_pc4 & 32'hF000_0000) | ({6'b0, jump_index_i} * 4); bubble = 1'b1;
    end else begin
      n_pc = m_pc + 4; n_instr = mem_word(m_pc, mem_mode); n_pc4 = m_pc + 4; n_valid = 1'b1;
      m_fetch = m_fetch + 1;
    end
    if (bubble) begin
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; m_bubble = m_bubble + 1;
    end
    @(posedge clk_i);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    @(negedge clk_i); @(negedge clk_i);
    check("rst/addr", imem.imem_addr, 32'h0);
    check("rst/instr", if_id_instr_o, 32'h0);
    check("rst/valid", {31'b0, if_id_valid_o}, 32'h0);
    check_all("rst");
    rst_i = 1'b1;

    // Sequential fetch, word == address
    tick("seq0"); check("seq0/lit", if_id_instr_o, 32'h0);
    tick("seq1"); check("seq1/lit", if_id_instr_o, 32'h4);
    tick("seq2"); check("seq2/lit", if_id_pc4_o, 32'hC);
    tick("seq3");

    // Stall at pc 0x10 for 3 cycles
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall/addr_lit", imem.imem_addr, 32'h10);
      check("stall/instr_lit", if_id_instr_o, 32'hC);
    end
    stall_i = 1'b0;
    tick("unstall"); check("unstall/lit", if_id_instr_o, 32'h10);

    // jr into segment 0x004..., then j with pc4 0x0040_0008
    jr_i = 1'b1; jr_target_i = 32'h0040_0004;
    tick("jr1");
    jr_i = 1'b0;
    tick("jr1seq"); check("jr1seq/pc4_lit", if_id_pc4_o, 32'h0040_0008);
    jump_i = 1'b1; jump_index_i = 26'h0000100;
    tick("jump"); check("jump/addr_lit", imem.imem_addr, 32'h0000_0400);
    check("jump/valid_lit", {31'b0, if_id_valid_o}, 32'h0);
    jump_i = 1'b0;

    // Branch overrides stall; jr beats jump
    branch_taken_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h200;
    tick("brstall"); check("brstall/addr_lit", imem.imem_addr, 32'h200);
    branch_taken_i = 1'b0; stall_i = 1'b0;
    jr_i = 1'b1; jump_i = 1'b1; jr_target_i = 32'h303;
    tick("jrjump"); check("jrjump/addr_lit", imem.imem_addr, 32'h300);
    jr_i = 1'b0; jump_i = 1'b0;

    // PC wrap
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick("wrapbr");
    branch_taken_i = 1'b0;
    tick("wrap"); check("wrap/addr_lit", imem.imem_addr, 32'h0);
    check("wrap/instr_lit", if_id_instr_o, 32'hFFFF_FFFC);

    // Asynchronous reset mid-cycle
    tick("prerst");
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    check("arst/instr_lit", if_id_instr_o, 32'h0);
    check("arst/addr_lit", imem.imem_addr, 32'h0);
    check_all("arst");
    #3 rst_i = 1'b1;

    // Perf scenario: 5 fetches, 1 jump, 2 stall cycles
    for (int i = 0; i < 5; i++) tick("pseq");
    jump_i = 1'b1; jump_index_i = 26'h40;
    tick("pjump");
    jump_i = 1'b0; stall_i = 1'b1;
    tick("pstall0"); tick("pstall1");
    stall_i = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf/fetch_lit", perf_fetch_cnt_o, 32'd5);
    check("perf/bubble_lit", perf_bubble_cnt_o, 32'd1);
`endif

    // Randomized traffic against the model
    mem_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      branch_taken_i  = ($urandom_range(0, 7) == 0);
      branch_target_i = $urandom & 32'hFFFF_FFFC;
      stall_i         = ($urandom_range(0, 3) == 0);
      jr_i            = ($urandom_range(0, 7) == 0);
      jr_target_i     = $urandom;
      jump_i          = ($urandom_range(0, 7) == 0);
      jump_index_i    = 26'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the decode stage (opcode bits [31:26] go to the control decoder). Handles sequential fetch, taken-branch redirect from EX, j/jal/jr redirect from ID, load-use stall and wrong-path bubble insertion.

## Interface
- ADDR_W, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold PC and IF/ID (load-use hazard from ID)
- branch_taken_i  in  1  beq resolved taken in EX
- branch_target_i  in  ADDR_W  branch target from EX
- jump_i  in  1  j/jal in ID
- jump_index_i  in  26  instr[25:0] of the j/jal in ID
- jr_i  in  1  jr in ID
- jr_target_i  in  ADDR_W  rs value for jr
- imem_addr_o  out  ADDR_W  instruction-memory byte address
- imem_data_i  in  32  instruction word, combinational read of imem_addr_o
- if_id_instr_o  out  32  registered instruction
- if_id_pc4_o  out  ADDR_W  registered PC+4 of that instruction
- if_id_valid_o  out  1  0 = bubble
- instr_op_o  out  6  if_id_instr_o[31:26], to decoder

## Operation
- imem_addr_o = pc_q combinationally; fetched word captured at next rising edge.
- Next-PC priority, evaluated each cycle:
  1. branch_taken_i: pc <= branch_target_i; IF/ID <= bubble. Overrides stall_i (branch is older).
  2. else stall_i: pc and IF/ID hold; jump_i/jr_i ignored.
  3. else jr_i: pc <= {jr_target_i[ADDR_W-1:2], 2'b00}; IF/ID <= bubble.
  4. else jump_i: pc <= {if_id_pc4_o[31:28], jump_index_i, 2'b00}; IF/ID <= bubble.
  5. else: pc <= pc_q + 4; IF/ID <= {imem_data_i, pc_q + 4, valid=1}.
- Bubble = instr 32'h0000_0000 (sll $0,$0,0 NOP), pc4 0, valid 0.
- No delay slots: the word in IF at redirect is discarded. On branch_taken_i the ID-stage instruction is also wrong-path; its squash is the ID/EX register's job.
- PC arithmetic modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
- jr_i and jump_i both high: jr_i wins (decoder never produces this; not an error).

## Timing
- Reset (async assert, sync-safe deassert sampled on clk_i): pc_q = RESET_PC, if_id_instr_o = 0, if_id_pc4_o = 0, if_id_valid_o = 0, instr_op_o = 0; perf counters 0.
- Fetch latency: 1 cycle, address to if_id_instr_o.
- Redirect penalty: 1 bubble for j/jal/jr, 1 bubble here (+1 downstream) for taken branch.
- Stall has no limit; releasing stall resumes from held pc_q with no lost or duplicated fetch.
- Reset asserted mid-stall or mid-redirect: all state to reset values immediately; pending redirect lost.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetch_cnt_o[31:0] (increments on each valid IF/ID load) and perf_bubble_cnt_o[31:0] (increments on each bubble load, not on stall-hold cycles); both wrap at 2^32, clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- cpu_pkg: NOP_INSTR = 32'h0, opcode constants OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100; typedef enum logic [1:0] pc_sel_e {PC_SEQ, PC_BRANCH, PC_JR, PC_JUMP}.
- Sub-module pc_next_sel: combinational priority mux producing pc_sel_e and next PC; fetch_stage holds PC register, IF/ID register and perf counters.

## Test plan
- Reset release, imem returns word = address: if_id_instr_o shows 0x0, 0x4, 0x8 on successive cycles, if_id_pc4_o 0x4, 0x8, 0xC, valid=1.
- stall_i high 3 cycles at pc_q=0x10: imem_addr_o stays 0x10, IF/ID holds instr@0xC; after release next loaded instr is 0x10.
- jump_i with if_id_pc4_o=0x0040_0008, jump_index_i=26'h0000100: next pc 0x0000_0400, one bubble (valid=0, instr 0).
- branch_taken_i=1 and stall_i=1 same cycle, target 0x200: pc becomes 0x200, bubble loaded; jr_i=1 with jump_i=1, jr_target_i=0x303: pc 0x300.
- pc_q=0xFFFF_FFFC sequential: next pc 0x0; rst_i pulsed low mid-cycle: outputs zero immediately, pc = RESET_PC.
- FETCH_PERF_EN: 5 sequential fetches, 1 jump, 2 stall cycles -> perf_fetch_cnt_o = 5, perf_bubble_cnt_o = 1.
